// File: rtl/mux_select_sequencer_pkg.sv
// Shared constants and types for the MUX select sequencer.
package mux_seq_pkg;
    localparam int NUM_INPUTS = 8;
    localparam int SEL_W      = 3;
    localparam int GAP_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } seq_state_e;
endpackage

// File: rtl/mux_select_sequencer_if.sv
// Word handshake, MUX drive/return and serial stream signals of the sequencer.
interface mux_select_sequencer_if;
    import mux_seq_pkg::*;

    logic [NUM_INPUTS-1:0] Word_In;
    logic                  Word_Valid_In;
    logic                  Word_Ready_Out;
    logic [NUM_INPUTS-1:0] Mux_Data_Out;
    logic [SEL_W-1:0]      Mux_Select_Out;
    logic                  Mux_Enable_Out;
    logic                  Mux_Bit_In;
    logic                  Serial_Data_Out;
    logic                  Serial_Valid_Out;
    logic                  Frame_Start_Out;
    logic                  Frame_Done_Out;
    logic                  Check_Error_Out;

    // Sequencer side
    modport master (
        input  Word_In, Word_Valid_In, Mux_Bit_In,
        output Word_Ready_Out, Mux_Data_Out, Mux_Select_Out, Mux_Enable_Out,
        output Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out,
        output Frame_Done_Out, Check_Error_Out
    );

    // Environment side (word source, MUX, serial sink)
    modport slave (
        output Word_In, Word_Valid_In, Mux_Bit_In,
        input  Word_Ready_Out, Mux_Data_Out, Mux_Select_Out, Mux_Enable_Out,
        input  Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out,
        input  Frame_Done_Out, Check_Error_Out
    );
endinterface

// File: rtl/mux_select_sequencer.sv
// Drives an 8:1 MUX through all select indices for an accepted word, turns the
// returned bits into a framed serial stream and checks them against the word.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    mux_select_sequencer_if.master bus
);

    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(NUM_INPUTS - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(NUM_INPUTS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [NUM_INPUTS-1:0] word_q, word_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  ready_q, ready_d;
    logic                  enable_q, enable_d;
    logic                  ser_data_q, ser_data_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  in_shift;

    assign in_shift = (state_q == SHIFT);

    // Next-state, index/gap counting, serial capture and self-check.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        sel_d       = sel_q;
        gap_d       = gap_q;
        error_d     = error_q;
        // Returned bit is registered one cycle after its select cycle.
        ser_valid_d = in_shift;
        ser_data_d  = in_shift & bus.Mux_Bit_In;
        start_d     = in_shift && (sel_q == FIRST_IDX);
        done_d      = in_shift && (sel_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (bus.Word_Valid_In && ready_q) begin
                    word_d  = bus.Word_In;
                    sel_d   = FIRST_IDX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.Mux_Bit_In != word_q[sel_q]) begin
                    error_d = 1'b1;
                end
                if (sel_q == LAST_IDX) begin
                    sel_d   = '0;
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    sel_d = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase

        // Handshake/enable outputs are registered decodes of the next state.
        ready_d  = (state_d == IDLE);
        enable_d = (state_d == SHIFT);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q     <= IDLE;
            word_q      <= '0;
            sel_q       <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b1;
            enable_q    <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            enable_q    <= enable_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            start_q     <= start_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.Word_Ready_Out   = ready_q;
    assign bus.Mux_Data_Out     = word_q;
    assign bus.Mux_Select_Out   = sel_q;
    assign bus.Mux_Enable_Out   = enable_q;
    assign bus.Serial_Data_Out  = ser_data_q;
    assign bus.Serial_Valid_Out = ser_valid_q;
    assign bus.Frame_Start_Out  = start_q;
    assign bus.Frame_Done_Out   = done_q;
    assign bus.Check_Error_Out  = error_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench: three sequencer configurations, each looped back through an
// 8:1 MUX model; instance 0 can invert the returned bit at one select index.
module tb_mux_select_sequencer;
    import mux_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic       inj_en;
    logic [2:0] inj_idx;

    int n_cmp = 0;
    int n_err = 0;

    mux_select_sequencer_if bus0();
    mux_select_sequencer_if bus1();
    mux_select_sequencer_if bus2();

    mux_select_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_dut0 (
        .Clock_In(clk), .Reset_In(rst0), .bus(bus0.master));
    mux_select_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_dut1 (
        .Clock_In(clk), .Reset_In(rst1), .bus(bus1.master));
    mux_select_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut2 (
        .Clock_In(clk), .Reset_In(rst2), .bus(bus2.master));

    // 8:1 MUX models with combinational return path
    assign bus0.Mux_Bit_In = bus0.Mux_Enable_Out &
        (bus0.Mux_Data_Out[bus0.Mux_Select_Out] ^ (inj_en && (bus0.Mux_Select_Out == inj_idx)));
    assign bus1.Mux_Bit_In = bus1.Mux_Enable_Out & bus1.Mux_Data_Out[bus1.Mux_Select_Out];
    assign bus2.Mux_Bit_In = bus2.Mux_Enable_Out & bus2.Mux_Data_Out[bus2.Mux_Select_Out];

    logic [7:0] o_data;
    logic [2:0] o_sel;
    logic       o_en, o_rdy, o_sd, o_sv, o_fs, o_fd, o_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int inst);
        case (inst)
            0: begin
                o_data = bus0.Mux_Data_Out;   o_sel = bus0.Mux_Select_Out;
                o_en   = bus0.Mux_Enable_Out; o_rdy = bus0.Word_Ready_Out;
                o_sd   = bus0.Serial_Data_Out; o_sv = bus0.Serial_Valid_Out;
                o_fs   = bus0.Frame_Start_Out; o_fd = bus0.Frame_Done_Out;
                o_err  = bus0.Check_Error_Out;
            end
            1: begin
                o_data = bus1.Mux_Data_Out;   o_sel = bus1.Mux_Select_Out;
                o_en   = bus1.Mux_Enable_Out; o_rdy = bus1.Word_Ready_Out;
                o_sd   = bus1.Serial_Data_Out; o_sv = bus1.Serial_Valid_Out;
                o_fs   = bus1.Frame_Start_Out; o_fd = bus1.Frame_Done_Out;
                o_err  = bus1.Check_Error_Out;
            end
            default: begin
                o_data = bus2.Mux_Data_Out;   o_sel = bus2.Mux_Select_Out;
                o_en   = bus2.Mux_Enable_Out; o_rdy = bus2.Word_Ready_Out;
                o_sd   = bus2.Serial_Data_Out; o_sv = bus2.Serial_Valid_Out;
                o_fs   = bus2.Frame_Start_Out; o_fd = bus2.Frame_Done_Out;
                o_err  = bus2.Check_Error_Out;
            end
        endcase
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] w);
        case (inst)
            0:       begin bus0.Word_Valid_In = v; bus0.Word_In = w; end
            1:       begin bus1.Word_Valid_In = v; bus1.Word_In = w; end
            default: begin bus2.Word_Valid_In = v; bus2.Word_In = w; end
        endcase
    endtask

    task automatic check_reset_state(input int inst);
        sample(inst);
        check_eq("rst_ready", o_rdy, 1);
        check_eq("rst_enable", o_en, 0);
        check_eq("rst_select", o_sel, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_sdata", o_sd, 0);
        check_eq("rst_svalid", o_sv, 0);
        check_eq("rst_start", o_fs, 0);
        check_eq("rst_done", o_fd, 0);
        check_eq("rst_error", o_err, 0);
    endtask

    // One frame from accept (cycle 0) to Ready back (cycle 9+gap).
    // inj >= 0 inverts the returned bit at that select index (instance 0 only);
    // pulse drives a foreign word with Valid during SHIFT and GAP.
    task automatic frame_check(input int inst, input logic [7:0] word, input bit msb,
                               input int gap, input bit err0, input int inj, input bit pulse);
        int last;
        int i;
        int s;
        int sel_cyc;
        logic exp_sv, exp_bit, exp_err;
        logic [2:0] exp_sel;
        last    = 9 + gap;
        inj_en  = (inj >= 0);
        inj_idx = 3'(inj);
        sel_cyc = msb ? 8 - inj : inj + 1;
        drive(inst, 1'b1, word);
        tick();
        drive(inst, 1'b0, word);
        for (int cyc = 1; cyc <= last; cyc++) begin
            sample(inst);
            exp_sel = (cyc <= 8) ? 3'(msb ? 8 - cyc : cyc - 1) : 3'd0;
            exp_sv  = (cyc >= 2) && (cyc <= 9);
            i       = cyc - 2;
            s       = msb ? 7 - i : i;
            exp_bit = exp_sv ? (word[s[2:0]] ^ (inj == s)) : 1'b0;
            exp_err = err0 | ((inj >= 0) && (cyc > sel_cyc));
            check_eq("select", o_sel, exp_sel);
            check_eq("enable", o_en, cyc <= 8);
            check_eq("ready", o_rdy, cyc >= last);
            check_eq("mux_data", o_data, word);
            check_eq("svalid", o_sv, exp_sv);
            check_eq("sdata", o_sd, exp_bit);
            check_eq("fstart", o_fs, cyc == 2);
            check_eq("fdone", o_fd, cyc == 9);
            check_eq("check_err", o_err, exp_err);
            if (pulse && (cyc == 3 || cyc == 10)) drive(inst, 1'b1, ~word);
            else                                  drive(inst, 1'b0, word);
            if (cyc < last) tick();
        end
        inj_en = 1'b0;
        $display("frame inst=%0d word=%02h msb=%0d gap=%0d inj=%0d pulse=%0d checked",
                 inst, word, msb, gap, inj, pulse);
    endtask

    initial begin
        inj_en = 1'b0;
        inj_idx = 3'd0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00);
        tick();
        tick();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int k = 0; k < 3; k++) check_reset_state(k);

        // LSB-first, gap 2
        frame_check(0, 8'hA5, 1'b0, 2, 1'b0, -1, 1'b0);
        // MSB-first
        frame_check(1, 8'h3C, 1'b1, 2, 1'b0, -1, 1'b0);

        // Gap 0, Valid held: FF then 00 accepted 9 cycles apart
        drive(2, 1'b1, 8'hFF);
        tick();
        drive(2, 1'b1, 8'h00);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            sample(2);
            check_eq("b2b_ready", o_rdy, (cyc == 9) || (cyc == 18));
            check_eq("b2b_enable", o_en, (cyc <= 8) || (cyc >= 10 && cyc <= 17));
            check_eq("b2b_select", o_sel,
                     (cyc <= 8) ? cyc - 1 : ((cyc >= 10 && cyc <= 17) ? cyc - 10 : 0));
            check_eq("b2b_data", o_data, (cyc <= 9) ? 8'hFF : 8'h00);
            check_eq("b2b_svalid", o_sv, (cyc >= 2 && cyc <= 9) || (cyc >= 11));
            check_eq("b2b_sdata", o_sd, (cyc >= 2 && cyc <= 9));
            check_eq("b2b_fstart", o_fs, (cyc == 2) || (cyc == 11));
            check_eq("b2b_fdone", o_fd, (cyc == 9) || (cyc == 18));
            if (cyc == 10) drive(2, 1'b0, 8'h00);
            if (cyc < 18) tick();
        end
        $display("back-to-back inst=2 words=FF,00 checked");

        // Fault at index 3 sets the sticky flag; it survives a good frame
        frame_check(0, 8'h0F, 1'b0, 2, 1'b0, 3, 1'b0);
        frame_check(0, 8'hC6, 1'b0, 2, 1'b1, -1, 1'b0);

        // Reset at Select = 4 aborts the frame and clears the flag
        drive(0, 1'b1, 8'h5A);
        tick();
        drive(0, 1'b0, 8'h5A);
        for (int k = 0; k < 4; k++) tick();
        sample(0);
        check_eq("abort_select", o_sel, 4);
        check_eq("abort_err_before", o_err, 1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_reset_state(0);
        for (int k = 0; k < 4; k++) begin
            tick();
            sample(0);
            check_eq("abort_ready", o_rdy, 1);
            check_eq("abort_nodone", o_fd, 0);
            check_eq("abort_svalid", o_sv, 0);
        end
        $display("abort inst=0 word=5A checked");
        frame_check(0, 8'h81, 1'b0, 2, 1'b0, -1, 1'b0);

        // Valid pulses in SHIFT and GAP are ignored
        frame_check(0, 8'hC3, 1'b0, 2, 1'b0, -1, 1'b1);
        tick();
        sample(0);
        check_eq("ignore_ready", o_rdy, 1);
        check_eq("ignore_data", o_data, 8'hC3);
        check_eq("ignore_enable", o_en, 0);
        check_eq("ignore_svalid", o_sv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
